// File: rtl/alu128_seq_ctrl.sv
// Multi-cycle 128-bit ALU sequencer: walks the operands CHUNK bits per cycle, LSB chunk first.
// Optional ALU_SEQ_FLAGS_EN adds rsp_zero / rsp_ovf result flags.
module alu128_seq_ctrl #(
    parameter int WIDTH = 128,
    parameter int CHUNK = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_op1,
    input  logic [WIDTH-1:0] req_op2,
    input  logic [2:0]       req_opsel,
    input  logic             req_cin,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_cout,
    output logic             rsp_err,
`ifdef ALU_SEQ_FLAGS_EN
    output logic             rsp_zero,
    output logic             rsp_ovf,
`endif
    output logic             busy
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_op1;
    logic [WIDTH-1:0] r_op2;
    logic [2:0]       r_opsel;
    logic [WIDTH-1:0] r_result;
    logic             r_cout;
    logic             r_err;
`ifdef ALU_SEQ_FLAGS_EN
    logic             r_zero;
    logic             r_ovf;
    logic             w_cmsb;
`endif

    int               w_base;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_bx;
    logic [CHUNK-1:0] w_res;
    logic [CHUNK:0]   w_sum;
    logic             w_cnext;
    logic             w_illegal;
    logic             w_addsub;
    logic [WIDTH-1:0] w_result_next;

    always_comb begin
        w_base    = int'(r_cnt) * CHUNK;
        w_a       = r_op1[w_base +: CHUNK];
        w_b       = r_op2[w_base +: CHUNK];
        // SUB reuses the adder with an inverted operand; the +1 comes from the seeded carry
        w_bx      = (r_opsel == OP_SUB) ? ~w_b : w_b;
        w_sum     = {1'b0, w_a} + {1'b0, w_bx} + {{CHUNK{1'b0}}, r_carry};
        w_addsub  = (r_opsel == OP_ADD) || (r_opsel == OP_SUB);
        w_res     = '0;
        w_cnext   = 1'b0;
        w_illegal = 1'b0;
        case (r_opsel)
            OP_AND:         w_res = w_a & w_b;
            OP_OR:          w_res = w_a | w_b;
            OP_XOR:         w_res = w_a ^ w_b;
            OP_NOT:         w_res = ~w_a;
            OP_ADD, OP_SUB: begin
                w_res   = w_sum[CHUNK-1:0];
                w_cnext = w_sum[CHUNK];
            end
            default:        w_illegal = 1'b1;
        endcase
        w_result_next                   = r_result;
        w_result_next[w_base +: CHUNK]  = w_res;
`ifdef ALU_SEQ_FLAGS_EN
        w_cmsb = w_a[CHUNK-1] ^ w_bx[CHUNK-1] ^ w_sum[CHUNK-1];
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_carry  <= 1'b0;
            r_op1    <= '0;
            r_op2    <= '0;
            r_opsel  <= '0;
            r_result <= '0;
            r_cout   <= 1'b0;
            r_err    <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
            r_zero   <= 1'b0;
            r_ovf    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_op1   <= req_op1;
                        r_op2   <= req_op2;
                        r_opsel <= req_opsel;
                        r_carry <= (req_opsel == OP_ADD) ? req_cin : (req_opsel == OP_SUB);
                        r_cnt   <= '0;
                        r_err   <= 1'b0;
`ifdef ALU_SEQ_FLAGS_EN
                        r_zero  <= 1'b0;
                        r_ovf   <= 1'b0;
`endif
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_result <= w_result_next;
                    r_carry  <= w_cnext;
                    if (w_illegal) begin
                        r_err <= 1'b1;
                    end
                    if (r_cnt == LAST) begin
                        r_cnt   <= '0;
                        r_cout  <= w_cnext;
`ifdef ALU_SEQ_FLAGS_EN
                        r_zero  <= (w_result_next == '0);
                        r_ovf   <= w_addsub & (w_cmsb ^ w_sum[CHUNK]);
`endif
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_DONE: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign rsp_valid  = (r_state == S_DONE);
    assign rsp_result = r_result;
    assign rsp_cout   = r_cout;
    assign rsp_err    = r_err;
`ifdef ALU_SEQ_FLAGS_EN
    assign rsp_zero   = r_zero;
    assign rsp_ovf    = r_ovf;
`else
    logic w_unused;
    assign w_unused = w_addsub;
`endif

endmodule

// File: tb/tb_alu128_seq_ctrl.sv
// Scoreboard bench for alu128_seq_ctrl: expectations queued at accept, checked at response.
module tb_alu128_seq_ctrl;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [127:0] req_op1;
    logic [127:0] req_op2;
    logic [2:0]   req_opsel;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_result;
    logic         rsp_cout;
    logic         rsp_err;
    logic         busy;
`ifdef ALU_SEQ_FLAGS_EN
    logic         rsp_zero;
    logic         rsp_ovf;
`endif

    always #5 clk = ~clk;

    alu128_seq_ctrl #(.WIDTH(128), .CHUNK(32)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_opsel  (req_opsel),
        .req_cin    (req_cin),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_cout   (rsp_cout),
        .rsp_err    (rsp_err),
`ifdef ALU_SEQ_FLAGS_EN
        .rsp_zero   (rsp_zero),
        .rsp_ovf    (rsp_ovf),
`endif
        .busy       (busy)
    );

    typedef struct {
        logic [127:0] res;
        logic         cout;
        logic         err;
        logic         zero;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [127:0] a, input logic [127:0] b,
                                   input logic [2:0] op, input logic cin);
        exp_t         e;
        logic [128:0] s;
        logic [127:0] bb;
        e = '{res: '0, cout: 1'b0, err: 1'b0, zero: 1'b0, ovf: 1'b0};
        case (op)
            3'b000: e.res = a & b;
            3'b001: e.res = a | b;
            3'b010: e.res = a ^ b;
            3'b011: e.res = ~a;
            3'b100, 3'b101: begin
                bb     = (op == 3'b101) ? ~b : b;
                s      = {1'b0, a} + {1'b0, bb} + 129'((op == 3'b101) ? 1'b1 : cin);
                e.res  = s[127:0];
                e.cout = s[128];
                e.ovf  = (a[127] == bb[127]) && (s[127] != a[127]);
            end
            default: e.err = 1'b1;
        endcase
        e.zero = (e.res == '0);
        return e;
    endfunction

    task automatic send(input logic [127:0] a, input logic [127:0] b,
                        input logic [2:0] op, input logic cin);
        int n = 0;
        while (!req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("req_ready_before_send", 128'(req_ready), 128'(1));
        req_valid = 1'b1;
        req_op1   = a;
        req_op2   = b;
        req_opsel = op;
        req_cin   = cin;
        @(posedge clk); #1;
        sb.push_back(model(a, b, op, cin));
        // scramble inputs after the accept edge; the DUT must keep its latched copy
        req_valid = 1'b0;
        req_op1   = ~a;
        req_op2   = ~b;
        req_opsel = 3'b110;
        req_cin   = ~cin;
    endtask

    task automatic recv(input bit check_lat);
        int   n = 0;
        exp_t e;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (check_lat) chk("latency", 128'(n), 128'(4));
        if (sb.size() == 0) begin
            chk("scoreboard_nonempty", 128'(0), 128'(1));
            return;
        end
        e = sb.pop_front();
        chk("rsp_valid", 128'(rsp_valid), 128'(1));
        chk("rsp_result", rsp_result, e.res);
        chk("rsp_cout", 128'(rsp_cout), 128'(e.cout));
        chk("rsp_err", 128'(rsp_err), 128'(e.err));
        chk("req_ready_in_done", 128'(req_ready), 128'(0));
`ifdef ALU_SEQ_FLAGS_EN
        chk("rsp_zero", 128'(rsp_zero), 128'(e.zero));
        chk("rsp_ovf", 128'(rsp_ovf), 128'(e.ovf));
`endif
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        chk("rsp_valid_after_take", 128'(rsp_valid), 128'(0));
        chk("busy_after_take", 128'(busy), 128'(0));
        chk("result_held", rsp_result, e.res);
    endtask

    initial begin
        logic [127:0] all1;
        logic [127:0] pf0;
        logic [127:0] pff00;
        logic [127:0] msb;
        int           n;
        bit           seen;
        exp_t         e;

        all1  = '1;
        pf0   = {16{8'hF0}};
        pff00 = {8{16'hFF00}};
        msb   = {1'b1, 127'd0};

        rst = 1'b1; req_valid = 1'b0; req_op1 = '0; req_op2 = '0;
        req_opsel = '0; req_cin = 1'b0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("rst_rsp_result", rsp_result, 128'd0);
        chk("rst_rsp_cout", 128'(rsp_cout), 128'(0));
        chk("rst_rsp_err", 128'(rsp_err), 128'(0));
        chk("rst_busy", 128'(busy), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_req_ready", 128'(req_ready), 128'(1));

        // carry ripple across every chunk boundary
        send(all1, 128'd1, 3'b100, 1'b0); recv(1);
        send(128'd5, 128'd7, 3'b101, 1'b0); recv(1);
        send(msb, 128'd1, 3'b101, 1'b0); recv(1);
        send(msb - 128'd1, 128'd1, 3'b100, 1'b0); recv(1);
        send(128'd3, 128'd3, 3'b101, 1'b0); recv(1);
        send(all1, 128'd0, 3'b100, 1'b1); recv(1);

        for (int i = 0; i < 4; i++) begin
            send(pf0, pff00, 3'(i), 1'b1); recv(1);
        end

        send(pf0, pff00, 3'b110, 1'b1); recv(1);
        send(128'd10, 128'd20, 3'b100, 1'b1); recv(1);
        send(all1, all1, 3'b111, 1'b0); recv(1);
        send(pf0, pff00, 3'b000, 1'b0); recv(1);

        for (int i = 0; i < 8; i++) begin
            send({$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom},
                 3'($urandom_range(0, 5)), 1'($urandom_range(0, 1)));
            recv(1);
        end

        // backpressure: response held while a new request waits
        send(128'hDEAD_BEEF, 128'h1234_5678_9ABC, 3'b100, 1'b1);
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        e = sb[0];
        req_valid = 1'b1; req_op1 = 128'd100; req_op2 = 128'd1; req_opsel = 3'b101; req_cin = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_rsp_valid", 128'(rsp_valid), 128'(1));
            chk("bp_req_ready", 128'(req_ready), 128'(0));
            chk("bp_result", rsp_result, e.res);
        end
        recv(0);
        chk("bp_ready_after_release", 128'(req_ready), 128'(1));
        @(posedge clk); #1;
        sb.push_back(model(128'd100, 128'd1, 3'b101, 1'b0));
        req_valid = 1'b0;
        chk("bp_accept_busy", 128'(busy), 128'(1));
        recv(1);

        // reset two cycles into RUN discards the operation
        send(all1, 128'd1, 3'b100, 1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        void'(sb.pop_back());
        chk("midrst_busy", 128'(busy), 128'(0));
        chk("midrst_rsp_valid", 128'(rsp_valid), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_req_ready", 128'(req_ready), 128'(1));
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("midrst_no_rsp", 128'(seen), 128'(0));
        send(128'd7, 128'd9, 3'b100, 1'b1); recv(1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
